// File: rtl/conv_pkg.sv
// Shared widths and window tap indices for the Conv2d 3x3 datapath.
package conv_pkg;

  localparam int unsigned PIXEL_WIDTH  = 16;
  localparam int unsigned KERNEL_WIDTH = 16;
  localparam int unsigned RESULT_WIDTH = 48;
  localparam int unsigned WIN_TAPS     = 9;

  // Tap k = 3*row + col; x00 sits at the LSBs of a window bus, x22 at the MSBs.
  localparam int unsigned X00 = 0;
  localparam int unsigned X01 = 1;
  localparam int unsigned X02 = 2;
  localparam int unsigned X10 = 3;
  localparam int unsigned X11 = 4;
  localparam int unsigned X12 = 5;
  localparam int unsigned X20 = 6;
  localparam int unsigned X21 = 7;
  localparam int unsigned X22 = 8;

  // Bus slot of tap x_rc.
  function automatic int unsigned tap_idx(input int unsigned r, input int unsigned c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two-row circular line store: one read and one write at the same column per accepted pixel.
// Contents are never cleared; the window generator masks stale entries by stream position.
module conv_line_buffer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1
);

  logic [WIDTH-1:0] row0_mem [DEPTH];
  logic [WIDTH-1:0] row1_mem [DEPTH];

  // Asynchronous read of the previous row (row0) and the row before it (row1).
  assign rd0 = row0_mem[addr];
  assign rd1 = row1_mem[addr];

  // Age the column: row0 moves to row1, new pixel lands in row0.
  always_ff @(posedge clk) begin
    if (we) begin
      row1_mem[addr] <= row0_mem[addr];
      row0_mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv3x3_window_gen.sv
// Streaming 3x3 window generator feeding the 3x3 multiply-adder.
// Optional build macro CONV_ZERO_PAD_EN: same-padding with internally generated phantom
// zero column/row; default build emits valid-only windows.
module conv3x3_window_gen #(
  parameter int unsigned PIXEL_WIDTH = conv_pkg::PIXEL_WIDTH,
  parameter int unsigned IMG_W       = 32,
  parameter int unsigned IMG_H       = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PIXEL_WIDTH-1:0]   in_pixel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [9*PIXEL_WIDTH-1:0] out_win,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  import conv_pkg::*;

`ifdef CONV_ZERO_PAD_EN
  localparam int unsigned STREAM_W = IMG_W + 1;
  localparam int unsigned STREAM_H = IMG_H + 1;
`else
  localparam int unsigned STREAM_W = IMG_W;
  localparam int unsigned STREAM_H = IMG_H;
`endif
  localparam int unsigned PW       = PIXEL_WIDTH;
  localparam int unsigned CW       = $clog2(STREAM_W);
  localparam int unsigned RW       = $clog2(STREAM_H);
  localparam int unsigned WIN_BITS = WIN_TAPS * PW;

  logic [CW-1:0]           col_q, col_nxt_c;
  logic [RW-1:0]           row_q, row_nxt_c;
  // [row][col][bit]: flattening gives slot 3*row+col, matching the out_win layout.
  logic [2:0][2:0][PW-1:0] win_q, win_nxt_c, win_out_c;
  logic [PW-1:0]           pixel_c, lb0_rd, lb1_rd;
  logic                    out_en_c, advance_c, emit_c, last_c;
`ifdef CONV_ZERO_PAD_EN
  logic                    phantom_c;
`endif

  conv_line_buffer #(
    .WIDTH (PW),
    .DEPTH (STREAM_W),
    .AW    (CW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (advance_c),
    .addr  (col_q),
    .wdata (pixel_c),
    .rd0   (lb0_rd),
    .rd1   (lb1_rd)
  );

  // Handshake, stream advance, next window and emission decision.
  always_comb begin
    out_en_c  = !out_valid || out_ready;
`ifdef CONV_ZERO_PAD_EN
    phantom_c = (col_q == CW'(IMG_W)) || (row_q == RW'(IMG_H));
    in_ready  = rst_n && out_en_c && !phantom_c;
    advance_c = rst_n && out_en_c && (phantom_c || in_valid);
    pixel_c   = phantom_c ? '0 : in_pixel;
    emit_c    = (row_q >= RW'(1)) && (col_q >= CW'(1));
    last_c    = (row_q == RW'(IMG_H)) && (col_q == CW'(IMG_W));
`else
    in_ready  = rst_n && out_en_c;
    advance_c = in_ready && in_valid;
    pixel_c   = in_pixel;
    emit_c    = (row_q >= RW'(2)) && (col_q >= CW'(2));
    last_c    = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
`endif

    col_nxt_c = col_q + CW'(1);
    row_nxt_c = row_q;
    if (col_q == CW'(STREAM_W - 1)) begin
      col_nxt_c = '0;
      row_nxt_c = (row_q == RW'(STREAM_H - 1)) ? '0 : row_q + RW'(1);
    end

    // Shift left by one column; the newest column enters at col 2.
    win_nxt_c = win_q;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        win_nxt_c[r][c] = win_q[r][c+1];
      end
    end
    win_nxt_c[0][2] = lb1_rd;
    win_nxt_c[1][2] = lb0_rd;
    win_nxt_c[2][2] = pixel_c;

    win_out_c = win_nxt_c;
`ifdef CONV_ZERO_PAD_EN
    // Taps outside the image (index -1 or index IMG_H/IMG_W) read as zero.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if ((r == 0 && row_q == RW'(1)) || (r == 2 && row_q == RW'(IMG_H)) ||
            (c == 0 && col_q == CW'(1)) || (c == 2 && col_q == CW'(IMG_W))) begin
          win_out_c[r][c] = '0;
        end
      end
    end
`endif
  end

  // Stream position, window registers and the single output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q     <= '0;
      col_q     <= '0;
      win_q     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_win   <= '0;
    end else begin
      if (advance_c) begin
        row_q <= row_nxt_c;
        col_q <= col_nxt_c;
        win_q <= win_nxt_c;
      end
      if (advance_c && emit_c) begin
        out_valid <= 1'b1;
        out_win   <= WIN_BITS'(win_out_c);
        out_last  <= last_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Self-checking bench for conv3x3_window_gen (IMG_W=IMG_H=4, pixel = off + 4r + c).
module tb_conv3x3_window_gen;

  localparam int PW = 16;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WB = 9 * PW;
`ifdef CONV_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int SW = PAD ? W + 1 : W;
  localparam int SH = PAD ? H + 1 : H;

  typedef struct packed {
    logic [WB-1:0] win;
    logic          last;
  } win_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [PW-1:0] in_pixel;
  logic          in_valid;
  logic          in_ready;
  logic [WB-1:0] out_win;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  int   n_checks = 0;
  int   n_errors = 0;
  int   rdy_mode = 0;
  int   n_last   = 0;
  win_t exp_q[$];
  win_t got_q[$];

  conv3x3_window_gen #(
    .PIXEL_WIDTH (PW),
    .IMG_W       (W),
    .IMG_H       (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pixel  (in_pixel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_win   (out_win),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [WB-1:0] pk(input int v[9]);
    logic [WB-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[k*PW +: PW] = PW'(v[k]);
    return r;
  endfunction

  // Reference: every window of a frame, taps straight from the image with zero outside it.
  function automatic void exp_frame(input int off);
    int lo, hi_r, hi_c;
    lo   = PAD ? 0 : 1;
    hi_r = PAD ? H - 1 : H - 2;
    hi_c = PAD ? W - 1 : W - 2;
    for (int i = lo; i <= hi_r; i++) begin
      for (int j = lo; j <= hi_c; j++) begin
        win_t e;
        e.win = '0;
        for (int dr = 0; dr < 3; dr++) begin
          for (int dc = 0; dc < 3; dc++) begin
            int y, x, v;
            y = i - 1 + dr;
            x = j - 1 + dc;
            v = (y < 0 || y >= H || x < 0 || x >= W) ? 0 : off + W * y + x;
            e.win[(3*dr+dc)*PW +: PW] = PW'(v);
          end
        end
        e.last = (i == hi_r) && (j == hi_c);
        exp_q.push_back(e);
      end
    end
  endfunction

  // Monitor: stream-position model, handshake rules and scoreboard, sampled at negedge.
  int            sr, sc;
  bit            stall, trig;
  logic [WB-1:0] hold_win;
  logic          hold_last;
  always @(negedge clk) begin
    bit en, ph, adv;
    if (!rst_n) begin
      chk("rst_out_valid", WB'(out_valid), '0);
      chk("rst_in_ready", WB'(in_ready), '0);
      chk("rst_out_last", WB'(out_last), '0);
      chk("rst_out_win", out_win, '0);
      sr = 0; sc = 0; stall = 0; trig = 0;
    end else begin
      en = !out_valid || out_ready;
      ph = (sc >= W) || (sr >= H);
      chk("in_ready", WB'(in_ready), WB'(en && !ph));
      if (trig) chk("latency_valid", WB'(out_valid), WB'(1));
      if (stall) begin
        chk("hold_valid", WB'(out_valid), WB'(1));
        chk("hold_win", out_win, hold_win);
        chk("hold_last", WB'(out_last), WB'(hold_last));
      end
      if (out_valid && out_ready) begin
        win_t g;
        g.win = out_win;
        g.last = out_last;
        got_q.push_back(g);
        if (out_last) n_last++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra_window act=%0h exp=none", out_win);
        end else begin
          win_t e;
          e = exp_q.pop_front();
          chk("window", out_win, e.win);
          chk("window_last", WB'(out_last), WB'(e.last));
        end
      end
      stall     = out_valid && !out_ready;
      hold_win  = out_win;
      hold_last = out_last;
      trig      = 0;
      adv       = ph ? en : (in_valid && in_ready);
      if (adv) begin
        if (!PAD) trig = (sr >= 2) && (sc >= 2);
        if (sc == SW - 1) begin
          sc = 0;
          sr = (sr == SH - 1) ? 0 : sr + 1;
        end else begin
          sc = sc + 1;
        end
      end
    end
  end

  // Downstream ready generator: 0 = always ready, 1 = random, 2 = driven by the test.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic push_pix(input logic [PW-1:0] p);
    int t;
    t = 0;
    in_pixel = p;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL push_timeout act=%0d exp=accepted", p);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int off, input int gap);
    for (int i = 0; i < W * H; i++) begin
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
        @(posedge clk);
        #1;
      end
      push_pix(PW'(off + i));
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_pending", WB'(exp_q.size()), '0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    got_q.delete();
    n_last = 0;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    if (!PAD) begin
      // T1: continuous input
      start_test();
      exp_frame(0);
      send_frame(0, 0);
      drain();
      chk("t1_count", WB'(got_q.size()), WB'(4));
      chk("t1_nlast", WB'(n_last), WB'(1));
      if (got_q.size() >= 4) begin
        chk("t1_first", got_q[0].win, pk('{0, 1, 2, 4, 5, 6, 8, 9, 10}));
        chk("t1_last_win", got_q[3].win, pk('{5, 6, 7, 9, 10, 11, 13, 14, 15}));
        chk("t1_last_flag", WB'(got_q[3].last), WB'(1));
        chk("t1_first_flag", WB'(got_q[0].last), WB'(0));
      end

      // T2: 3-cycle backpressure on the first window
      start_test();
      rdy_mode = 2;
      exp_frame(0);
      fork
        send_frame(0, 0);
        begin
          int t;
          t = 0;
          do begin
            @(posedge clk);
            #1;
            t++;
          end while (!out_valid && t < 200);
          out_ready = 1'b0;
          repeat (3) @(posedge clk);
          #1 out_ready = 1'b1;
        end
      join
      rdy_mode = 0;
      drain();
      chk("t2_count", WB'(got_q.size()), WB'(4));
      if (got_q.size() >= 1) chk("t2_first", got_q[0].win, pk('{0, 1, 2, 4, 5, 6, 8, 9, 10}));

      // T3: random input gaps and random downstream ready
      start_test();
      rdy_mode = 1;
      exp_frame(0);
      send_frame(0, 50);
      drain();
      rdy_mode = 0;
      drain();
      chk("t3_count", WB'(got_q.size()), WB'(4));

      // T4: back-to-back frames, second offset by 100
      start_test();
      exp_frame(0);
      exp_frame(100);
      send_frame(0, 0);
      send_frame(100, 0);
      drain();
      chk("t4_count", WB'(got_q.size()), WB'(8));
      chk("t4_nlast", WB'(n_last), WB'(2));
      if (got_q.size() >= 8) begin
        chk("t4_fifth", got_q[4].win, pk('{100, 101, 102, 104, 105, 106, 108, 109, 110}));
        chk("t4_last", got_q[7].win, pk('{105, 106, 107, 109, 110, 111, 113, 114, 115}));
      end

      // T5: reset after 9 pixels, then a full frame
      start_test();
      for (int i = 0; i < 9; i++) push_pix(PW'(i));
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_frame(0);
      send_frame(0, 0);
      drain();
      chk("t5_count", WB'(got_q.size()), WB'(4));
      if (got_q.size() >= 4) begin
        chk("t5_first", got_q[0].win, pk('{0, 1, 2, 4, 5, 6, 8, 9, 10}));
        chk("t5_last", got_q[3].win, pk('{5, 6, 7, 9, 10, 11, 13, 14, 15}));
      end
    end else begin
      // T6: same-padding, continuous
      start_test();
      exp_frame(0);
      send_frame(0, 0);
      drain();
      chk("t6_count", WB'(got_q.size()), WB'(16));
      chk("t6_nlast", WB'(n_last), WB'(1));
      if (got_q.size() >= 16) begin
        chk("t6_first", got_q[0].win, pk('{0, 0, 0, 0, 0, 1, 0, 4, 5}));
        chk("t6_center", got_q[5].win, pk('{0, 1, 2, 4, 5, 6, 8, 9, 10}));
        chk("t6_last_win", got_q[15].win, pk('{10, 11, 0, 14, 15, 0, 0, 0, 0}));
        chk("t6_last_flag", WB'(got_q[15].last), WB'(1));
      end

      // T6b: padded frame offset by 100 under random gaps and ready
      start_test();
      rdy_mode = 1;
      exp_frame(100);
      send_frame(100, 40);
      drain();
      rdy_mode = 0;
      drain();
      chk("t6b_count", WB'(got_q.size()), WB'(16));
      chk("t6b_nlast", WB'(n_last), WB'(1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
